// File: rtl/ahbl_sram_mem_ctrl.sv
// AHB-Lite SRAM back end: executes one captured single transfer on a synchronous
// single-port RAM with byte enables, returning a done pulse and held read data.
module ahbl_sram_mem_ctrl #(
  parameter int AHB_DWIDTH = 32,
  parameter int MEM_AWIDTH = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  ram_req,
  input  logic                  ram_wen,
  input  logic [19:0]           ram_addr,
  input  logic [2:0]            ram_size,
  input  logic [AHB_DWIDTH-1:0] ram_wdata,
  output logic                  ram_done,
  output logic [AHB_DWIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [AHB_DWIDTH-1:0] mem_wdata,
  input  logic [AHB_DWIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LATENCY);

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic                  r_oor;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_ce;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [MEM_AWIDTH-1:0] r_addr;
  logic [AHB_DWIDTH-1:0] r_wdata;
  logic [AHB_DWIDTH-1:0] r_rdata;

  logic                  w_start;
  logic                  w_oor;
  logic                  w_rd_last;
  logic [3:0]            w_be;

  assign w_start   = (r_state == IDLE) && ram_req;
  assign w_oor     = |ram_addr[19:MEM_AWIDTH+2];
  assign w_rd_last = (r_state == READ) && (r_cnt == RD_LAST);

  always_comb begin
    w_be = 4'b1111;
    case (ram_size)
      3'b000:  w_be = 4'b0001 << ram_addr[1:0];
      3'b001:  w_be = ram_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ram_req) w_next = ram_wen ? WRITE : READ;
      WRITE:   w_next = RESP;
      READ:    if (r_cnt == RD_LAST) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The RAM-side registers are loaded straight from the request on the capture
  // edge, so the strobe appears in the first WRITE/READ cycle without a staging copy.
  // READ spans RD_LATENCY+1 cycles; mem_rdata is sampled in the last of them.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_oor   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == RESP);
      r_ce    <= w_start && !w_oor;
      r_we    <= w_start && ram_wen && !w_oor;
      if (w_start) begin
        r_addr <= ram_addr[MEM_AWIDTH+1:2];
        r_be   <= ram_wen ? w_be : 4'b1111;
        r_oor  <= w_oor;
        r_cnt  <= '0;
        if (ram_wen) r_wdata <= ram_wdata;
      end else if (r_state == READ) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_rd_last) r_rdata <= r_oor ? '0 : mem_rdata;
    end
  end

  assign ram_done  = r_done;
  assign ram_rdata = r_rdata;
  assign busy      = r_busy;
  assign mem_ce    = r_ce;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_ahbl_sram_mem_ctrl.sv
// Directed bench for ahbl_sram_mem_ctrl: three instances (RD_LATENCY 1..3) share
// stimulus, each with its own synchronous RAM read model.
module tb_ahbl_sram_mem_ctrl;

  localparam int NI = 3;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        ram_req = 1'b0;
  logic        ram_wen = 1'b0;
  logic [19:0] ram_addr = '0;
  logic [2:0]  ram_size = '0;
  logic [31:0] ram_wdata = '0;

  logic [NI-1:0]       done, busy, ce, we;
  logic [NI-1:0][31:0] rdata, mwdata, mrdata;
  logic [NI-1:0][3:0]  be;
  logic [NI-1:0][13:0] maddr;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] pipe [0:g];

    ahbl_sram_mem_ctrl #(
      .AHB_DWIDTH(32),
      .MEM_AWIDTH(14),
      .RD_LATENCY(g + 1)
    ) u_dut (
      .HCLK     (HCLK),
      .HRESETN  (HRESETN),
      .ram_req  (ram_req),
      .ram_wen  (ram_wen),
      .ram_addr (ram_addr),
      .ram_size (ram_size),
      .ram_wdata(ram_wdata),
      .ram_done (done[g]),
      .ram_rdata(rdata[g]),
      .busy     (busy[g]),
      .mem_ce   (ce[g]),
      .mem_we   (we[g]),
      .mem_be   (be[g]),
      .mem_addr (maddr[g]),
      .mem_wdata(mwdata[g]),
      .mem_rdata(mrdata[g])
    );

    // Read data is valid only RD_LATENCY cycles after the strobe; a poison value otherwise.
    always @(posedge HCLK) begin
      if (ce[g] && !we[g]) pipe[0] <= 32'hA5A50000 + {18'd0, maddr[g]};
      else                 pipe[0] <= 32'hDEAD0BAD;
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    assign mrdata[g] = pipe[g];
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[lat%0d] observed=%h expected=%h", tag, k + 1, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_busy"},  k, 32'(busy[k]),  32'd0);
      chk({tag, "_done"},  k, 32'(done[k]),  32'd0);
      chk({tag, "_rdata"}, k, rdata[k],      32'd0);
      chk({tag, "_ce"},    k, 32'(ce[k]),    32'd0);
      chk({tag, "_we"},    k, 32'(we[k]),    32'd0);
      chk({tag, "_be"},    k, 32'(be[k]),    32'd0);
      chk({tag, "_addr"},  k, 32'(maddr[k]), 32'd0);
      chk({tag, "_wdata"}, k, mwdata[k],     32'd0);
    end
  endtask

  task automatic do_write(input string tag, input logic [19:0] a, input logic [2:0] s,
                          input logic [31:0] d, input logic [3:0] ebe, input logic [13:0] eaddr);
    ram_req = 1'b1; ram_wen = 1'b1; ram_addr = a; ram_size = s; ram_wdata = d;
    tick();
    ram_req = 1'b0; ram_wdata = '0;
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_ce1"},   k, 32'(ce[k]),    32'd1);
      chk({tag, "_we1"},   k, 32'(we[k]),    32'd1);
      chk({tag, "_be"},    k, 32'(be[k]),    32'(ebe));
      chk({tag, "_addr"},  k, 32'(maddr[k]), 32'(eaddr));
      chk({tag, "_wdata"}, k, mwdata[k],     d);
      chk({tag, "_busy1"}, k, 32'(busy[k]),  32'd1);
      chk({tag, "_done1"}, k, 32'(done[k]),  32'd0);
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_ce2"},    k, 32'(ce[k]),   32'd0);
      chk({tag, "_we2"},    k, 32'(we[k]),   32'd0);
      chk({tag, "_done2"},  k, 32'(done[k]), 32'd1);
      chk({tag, "_busy2"},  k, 32'(busy[k]), 32'd1);
      chk({tag, "_whold"},  k, mwdata[k],    d);
      chk({tag, "_behold"}, k, 32'(be[k]),   32'(ebe));
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      chk({tag, "_done3"}, k, 32'(done[k]), 32'd0);
      chk({tag, "_busy3"}, k, 32'(busy[k]), 32'd0);
    end
  endtask

  // Read issued in cycle N; loop index c is cycle N+c. Latency of instance k is k+1.
  task automatic run_read(input string tag, input logic [19:0] a, input logic [31:0] exp,
                          input logic [31:0] prev, input logic exp_ce,
                          input logic [13:0] eaddr, input logic inject);
    int lat;
    ram_req = 1'b1; ram_wen = 1'b0; ram_addr = a; ram_size = 3'b010;
    tick();
    ram_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < NI; k++) begin
        lat = k + 1;
        chk({tag, "_ce"},   k, 32'(ce[k]),   (c == 1) ? 32'(exp_ce) : 32'd0);
        chk({tag, "_we"},   k, 32'(we[k]),   32'd0);
        chk({tag, "_done"}, k, 32'(done[k]), (c == 2 + lat) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, k, 32'(busy[k]), (c <= 2 + lat) ? 32'd1 : 32'd0);
        chk({tag, "_rdata"}, k, rdata[k],    (c >= 2 + lat) ? exp : prev);
        if (exp_ce) begin
          chk({tag, "_addr"}, k, 32'(maddr[k]), 32'(eaddr));
          if (c == 1) chk({tag, "_be"}, k, 32'(be[k]), 32'hF);
        end
      end
      if (inject && (c == 1 || c == 3)) begin
        ram_req = 1'b1; ram_wen = 1'b1; ram_addr = 20'h00200;
        ram_size = 3'b000; ram_wdata = 32'h12345678;
      end
      tick();
      ram_req = 1'b0; ram_wdata = '0;
    end
  endtask

  initial begin
    HRESETN = 1'b0;
    tick();
    tick();
    check_reset("rst");
    HRESETN = 1'b1;
    tick();

    do_write("wword", 20'h00010, 3'b010, 32'hDEADBEEF, 4'b1111, 14'd4);
    do_write("wbyte3", 20'h00003, 3'b000, 32'h11000000, 4'b1000, 14'd0);
    do_write("whalf2", 20'h00002, 3'b001, 32'h22330000, 4'b1100, 14'd0);
    do_write("whalf1", 20'h00001, 3'b001, 32'h00004455, 4'b0011, 14'd0);

    run_read("rd", 20'h00100, 32'hA5A50040, 32'd0, 1'b1, 14'h40, 1'b0);
    run_read("rdoor", 20'h10000, 32'd0, 32'hA5A50040, 1'b0, 14'd0, 1'b0);

    ram_req = 1'b1; ram_wen = 1'b1; ram_addr = 20'h10000; ram_size = 3'b010;
    ram_wdata = 32'h0BADF00D;
    tick();
    ram_req = 1'b0; ram_wdata = '0;
    for (int c = 1; c <= 3; c++) begin
      for (int k = 0; k < NI; k++) begin
        chk("wroor_ce",   k, 32'(ce[k]),   32'd0);
        chk("wroor_we",   k, 32'(we[k]),   32'd0);
        chk("wroor_done", k, 32'(done[k]), (c == 2) ? 32'd1 : 32'd0);
        chk("wroor_busy", k, 32'(busy[k]), (c <= 2) ? 32'd1 : 32'd0);
      end
      tick();
    end

    run_read("rdinj", 20'h00100, 32'hA5A50040, 32'd0, 1'b1, 14'h40, 1'b1);

    ram_req = 1'b1; ram_wen = 1'b0; ram_addr = 20'h00104; ram_size = 3'b010;
    tick();
    ram_req = 1'b0;
    for (int k = 0; k < NI; k++) chk("mrst_strobe", k, 32'(ce[k]), 32'd1);
    HRESETN = 1'b0;
    tick();
    check_reset("mrst");
    HRESETN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < NI; k++) begin
        chk("mrst_nodone", k, 32'(done[k]), 32'd0);
        chk("mrst_nobusy", k, 32'(busy[k]), 32'd0);
      end
      tick();
    end
    do_write("wpost", 20'h00020, 3'b010, 32'hCAFEF00D, 4'b1111, 14'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
